// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
// Define MULDIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow at acceptance.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(XLEN - 1);

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] prod;
    logic              div_signed, q_neg, r_neg, q_bit;
    logic [XLEN-1:0]   b_abs, in_a_abs, rem_nx, quo_nx, quo_fix, rem_fix, div_res;
    logic [XLEN:0]     shifted, diff;

    assign a_sgn = (f3_q[1:0] != 2'b11) & a_q[XLEN-1];
    assign b_sgn = ~f3_q[1] & b_q[XLEN-1];
    assign prod  = {{XLEN{a_sgn}}, a_q} * {{XLEN{b_sgn}}, b_q};

    // Restoring step on magnitudes: dividend bits shift out of quo_q as quotient bits shift in.
    assign div_signed = ~f3_q[0];
    assign b_abs      = (div_signed && b_q[XLEN-1]) ? -b_q : b_q;
    assign shifted    = {rem_q, quo_q[XLEN-1]};
    assign diff       = shifted - {1'b0, b_abs};
    assign q_bit      = ~diff[XLEN];
    assign rem_nx     = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx     = {quo_q[XLEN-2:0], q_bit};
    assign q_neg      = div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign r_neg      = div_signed & a_q[XLEN-1];

    always_comb begin
        quo_fix = q_neg ? -quo_nx : quo_nx;
        rem_fix = r_neg ? -rem_nx : rem_nx;
        // Overflow falls out of the magnitude path; divide-by-zero needs the sign fix-up bypassed.
        if (b_q == '0) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
        div_res = f3_q[1] ? rem_fix : quo_fix;
    end

    assign in_a_abs = (!funct3_i[0] && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;

`ifdef MULDIV_FAST_SPECIAL_EN
    logic            in_div0, in_ovf;
    logic [XLEN-1:0] in_special_res;
    assign in_div0 = (op_b_i == '0);
    assign in_ovf  = !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    always_comb begin
        if (in_div0) in_special_res = funct3_i[1] ? op_a_i : '1;
        else         in_special_res = funct3_i[1] ? '0 : op_a_i;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    f3_d    = funct3_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = in_a_abs;
                    state_d = funct3_i[2] ? S_DIV : S_MUL;
`ifdef MULDIV_FAST_SPECIAL_EN
                    if (funct3_i[2] && (in_div0 || in_ovf)) begin
                        result_d = in_special_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == DIV_LAST) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (kill_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latency of special divides follows MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.XLEN(32), .MUL_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start accepted in the current cycle (cycle 0); start_i stays high until done_o, as the core stalls.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res);
        int cyc;
        int busy_bad;
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        busy_bad = 0;
        step();
        cyc    = 1;
        op_a_i = $urandom;
        op_b_i = $urandom;
        while (!done_o && cyc < 100) begin
            if (!busy_o) busy_bad = 1;
            step();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        start_i = 1'b0;
        step();
        check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, "_hold"}, result_o, exp_res);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [31:0] prev;
        rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
        funct3_i = 3'd0; op_a_i = '0; op_b_i = '0;
        #12;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        step();
        rst_i = 1'b0;
        step();

        do_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFEB);
        do_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 2, 32'h40000000);
        do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
        do_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);

        do_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
        do_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
        do_op("divu", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        do_op("remu", 3'b111, 32'd100, 32'd7, 33, 32'd2);

        do_op("divu0", 3'b101, 32'd100, 32'd0, SPEC_LAT, 32'hFFFFFFFF);
        do_op("remu0", 3'b111, 32'd100, 32'd0, SPEC_LAT, 32'd100);
        do_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'h80000000);
        do_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'd0);
        do_op("divneg0", 3'b100, 32'hFFFFFFF9, 32'd0, SPEC_LAT, 32'hFFFFFFFF);
        do_op("remneg0", 3'b110, 32'hFFFFFFF9, 32'd0, SPEC_LAT, 32'hFFFFFFF9);

        // kill together with start in IDLE: nothing accepted
        start_i = 1'b1; kill_i = 1'b1; funct3_i = 3'b101; op_a_i = 32'd9; op_b_i = 32'd3;
        step();
        check("killstart_busy", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0; kill_i = 1'b0;
        step();

        // kill in cycle 10 of a DIVU
        prev = result_o;
        start_i = 1'b1; funct3_i = 3'b101; op_a_i = 32'd1000; op_b_i = 32'd3;
        step();
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("kill_busy_c10", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check("kill_busy_c11", {31'd0, busy_o}, 32'd0);
        check("kill_done_c11", {31'd0, done_o}, 32'd0);
        check("kill_result", result_o, prev);
        step();
        do_op("after_kill", 3'b101, 32'd1000, 32'd3, 33, 32'd333);

        // async reset mid-DIV
        start_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'hFFFFFFF9; op_b_i = 32'd2;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("arst_busy_before", {31'd0, busy_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        #1 rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_o) seen = 1;
        end
        check("arst_no_done", 32'(seen), 32'd0);

        // back-to-back MUL then DIVU; the DIVU request is ignored in DONE and taken the next cycle
        start_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd7; op_b_i = 32'hFFFFFFFD;
        step();
        cyc = 1;
        while (!done_o && cyc < 10) begin
            step();
            cyc++;
        end
        check("b2b_mul_lat", 32'(cyc), 32'd2);
        check("b2b_mul_res", result_o, 32'hFFFFFFEB);
        funct3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7;
        step();
        cyc++;
        check("b2b_idle_busy", {31'd0, busy_o}, 32'd0);
        step();
        cyc++;
        check("b2b_div_busy", {31'd0, busy_o}, 32'd1);
        op_a_i = $urandom; op_b_i = $urandom;
        while (!done_o && cyc < 100) begin
            step();
            cyc++;
        end
        check("b2b_div_lat", 32'(cyc), 32'd36);
        check("b2b_div_res", result_o, 32'd14);
        start_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
